// File: rtl/mdu_pkg.sv
// MDU shared definitions: op encodings and control FSM state type.
// Imported by mdu and mdu_arith.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic is_mul(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// MDU combinational core: {hi,lo} result for MULT/MULTU/DIV/DIVU.
// Ports: a, b, op in; res (2*WIDTH, hi in upper half) out.
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic [2*WIDTH-1:0] res
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [W2-1:0]    LO_MASK = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

   logic signed [W2-1:0] sa, sb, sq, sr;
   logic        [W2-1:0] ua, ub, uq, ur;

   // operands extended to 2*WIDTH so no intermediate is truncated
   assign sa = W2'($signed(a));
   assign sb = W2'($signed(b));
   assign ua = {{WIDTH{1'b0}}, a};
   assign ub = {{WIDTH{1'b0}}, b};

   always_comb begin
      sq  = '0;
      sr  = '0;
      uq  = '0;
      ur  = '0;
      res = '0;
      unique case (op)
         OP_MULT:  res = sa * sb;
         OP_MULTU: res = ua * ub;
         OP_DIV: begin
            if (b == '0) begin
               res = {a, {WIDTH{1'b1}}};
            end else if (a == MIN_NEG && &b) begin
               res = {{WIDTH{1'b0}}, a};
            end else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = (sr << WIDTH) | (sq & LO_MASK);
            end
         end
         OP_DIVU: begin
            if (b == '0) begin
               res = {a, {WIDTH{1'b1}}};
            end else begin
               uq  = ua / ub;
               ur  = ua % ub;
               res = (ur << WIDTH) | (uq & LO_MASK);
            end
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit with HI/LO and fixed-latency busy window.
// Ports: clk, rst_n (sync, active-low), start, op, a, b; busy, done, hi, lo.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic             capture, finish, wr_hi, wr_lo;
   logic [2*WIDTH-1:0] res;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .res (res)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      finish  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (is_mul(op) || is_div(op)) begin
                  capture = 1'b1;
                  state_d = RUN;
                  cnt_d   = is_mul(op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               end
               wr_hi = (op == OP_MTHI);
               wr_lo = (op == OP_MTLO);
            end
         end
         RUN: begin
            // counter holds the cycles of busy left, including this one
            if (cnt_q == CW'(1)) begin
               finish  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done    <= finish;
         if (capture) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
         end
         if (finish) begin
            hi <= res[2*WIDTH-1:WIDTH];
            lo <= res[WIDTH-1:0];
         end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
         end
      end
   end

   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (WIDTH=32, 5/10 cycle latency).
// Checks busy window, done pulse, HI/LO results, MTHI/MTLO and reset abort.
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Issue a multi-cycle op from an idle cycle; ends on the done cycle.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] av, input logic [31:0] bv,
                         input int n, input logic [31:0] rhi,
                         input logic [31:0] rlo);
      int cnt;
      int guard;
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      step();
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0000_0003;
      chk({tag, "_done_lo_at_start"}, {31'b0, done}, 32'd0);
      cnt   = 0;
      guard = 0;
      while (busy && guard < 50) begin
         cnt++;
         guard++;
         if (done || hi !== exp_hi || lo !== exp_lo) begin
            chk({tag, "_hold_while_busy"}, {hi[30:0], done}, {exp_hi[30:0], 1'b0});
         end
         step();
      end
      chk({tag, "_busy_cycles"}, cnt, n);
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_hi"}, hi, rhi);
      chk({tag, "_lo"}, lo, rlo);
      exp_hi = rhi;
      exp_lo = rlo;
   endtask

   initial begin
      int seen_done;
      rst_n = 1'b0;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      step();
      step();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      rst_n = 1'b1;
      step();

      // back-to-back: each op starts on the previous op's done cycle
      run_op("mult", 3'b000, 32'hFFFF_FFFF, 32'd2, 5,
             32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5,
             32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu0", 3'b011, 32'd7, 32'd0, 10,
             32'd7, 32'hFFFF_FFFF);
      run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10,
             32'd0, 32'h8000_0000);
      run_op("multu_big", 3'b001, 32'h0001_0000, 32'h0001_0000, 5,
             32'd1, 32'd0);
      run_op("divu", 3'b011, 32'd100, 32'd7, 10,
             32'd2, 32'd14);
      run_op("div_pos_neg", 3'b010, 32'd7, 32'hFFFF_FFFE, 10,
             32'd1, 32'hFFFF_FFFD);
      run_op("div0_signed", 3'b010, 32'hFFFF_FFF0, 32'd0, 10,
             32'hFFFF_FFF0, 32'hFFFF_FFFF);
      run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5,
             32'd0, 32'd15);

      // MTHI / MTLO from idle: immediate write, no busy, no done
      start = 1'b1;
      op    = 3'b100;
      a     = 32'h0000_ABCD;
      step();
      chk("mthi_hi", hi, 32'h0000_ABCD);
      chk("mthi_lo", lo, 32'd15);
      chk("mthi_busy", {31'b0, busy}, 32'd0);
      chk("mthi_done", {31'b0, done}, 32'd0);
      op = 3'b101;
      a  = 32'h0000_5555;
      step();
      chk("mtlo_lo", lo, 32'h0000_5555);
      chk("mtlo_hi", hi, 32'h0000_ABCD);
      op = 3'b110;
      a  = 32'h1111_1111;
      step();
      start = 1'b0;
      chk("rsvd_busy", {31'b0, busy}, 32'd0);
      chk("rsvd_hi", hi, 32'h0000_ABCD);
      chk("rsvd_lo", lo, 32'h0000_5555);
      step();
      chk("rsvd_done", {31'b0, done}, 32'd0);

      // MULT in flight, MTHI at busy cycle 2 ignored, reset at busy cycle 4
      seen_done = 0;
      start = 1'b1;
      op    = 3'b000;
      a     = 32'd3;
      b     = 32'd4;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      op    = 3'b100;
      a     = 32'h0000_1234;
      chk("abort_busy_c2", {31'b0, busy}, 32'd1);
      step();
      start = 1'b0;
      chk("abort_mthi_ignored", hi, 32'h0000_ABCD);
      step();
      chk("abort_busy_c4", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (done) seen_done++;
         step();
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_hi_after", hi, 32'd0);

      // start coincident with reset is discarded
      rst_n = 1'b0;
      start = 1'b1;
      op    = 3'b100;
      a     = 32'h0000_0099;
      step();
      rst_n = 1'b1;
      start = 1'b0;
      step();
      chk("rst_start_hi", hi, 32'd0);
      chk("rst_start_busy", {31'b0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
